dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 cpu_req_i / cpu_we_i  in  1/1  MEM-stage access request (held until granted) / store.
REQ-005 cpu_funct3_i  in  3  load/store width and sign, FUNCT3_* encoding.
REQ-006 cpu_addr_i / cpu_wdata_i  in  DATA_WIDTH each  byte address / store data (right-aligned).
REQ-007 cpu_gnt_o / cpu_stall_o / cpu_misalign_o  out  1 each  grant / pipeline stall / misaligned-access pulse.
REQ-008 cpu_rvalid_o / cpu_rdata_o  out  1/DATA_WIDTH  load data valid / extended load data.
REQ-009 dma_req_i / dma_we_i / dma_be_i  in  1/1/4  loader-port request (held until granted) / write / byte enables.
REQ-010 dma_addr_i / dma_wdata_i  in  DATA_WIDTH each  address (bits [1:0] ignored) / write word.
REQ-011 dma_gnt_o / dma_rvalid_o / dma_rdata_o  out  1/1/DATA_WIDTH  grant / read valid / raw read word.
REQ-012 mem_en_o / mem_we_o / mem_addr_o / mem_wdata_o  out  1/4/DATA_WIDTH/DATA_WIDTH  memory enable / byte write enables / word address ([1:0]=0) / lane-aligned data.
REQ-013 mem_rdata_i  in  DATA_WIDTH  synchronous-read memory data, valid one cycle after mem_en_o with mem_we_o=0.

Function
REQ-014 Arbitration is evaluated every cycle; at most one grant per cycle; gnt outputs are combinational from requests and arbiter state.
REQ-015 Default policy: fixed priority, CPU over DMA.
REQ-016 Granted access drives mem_en_o=1 in the grant cycle; ungranted cycles drive mem_en_o=0, mem_we_o=0.
REQ-017 Writes complete in the grant cycle; reads return *_rvalid_o=1 exactly one cycle after grant, for exactly one cycle.
REQ-018 Pending-read tracker states: NONE, CPU_RD, DMA_RD; next state set by the current-cycle read grant, else NONE; back-to-back reads (one per cycle) allowed.
REQ-019 CPU byte lanes: SB be=0001<<addr[1:0], data byte replicated to all lanes; SH be=0011<<(2*addr[1]), halfword replicated; SW be=1111.
REQ-020 CPU misaligned (SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0): granted, mem_en_o=0, cpu_misalign_o=1 that cycle, no rvalid.
REQ-021 CPU load extraction uses funct3 and addr[1:0] registered at grant: LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
REQ-022 DMA writes use dma_be_i verbatim; DMA reads return the raw word.
REQ-023 cpu_stall_o = (cpu_req_i & ~cpu_gnt_o) | (tracker==CPU_RD & ~cpu_rvalid_o); a CPU load stalls exactly one cycle when granted immediately.
REQ-024 Simultaneous cpu_req_i and dma_req_i while a read returns: return and new grant proceed in the same cycle.

Reset
REQ-025 During/after reset: all gnt, rvalid, stall, misalign, mem_en_o, mem_we_o = 0; rdata, mem_addr_o, mem_wdata_o = 0; tracker = NONE.
REQ-026 Reset mid-read drops the pending response; no rvalid follows reset release.
REQ-027 Round-robin pointer resets to "DMA last served" (CPU wins first tie).

Configuration
REQ-028 Macro DMEM_ARB_RR_EN defined: on simultaneous requests, grant the port not served by the most recent grant; pointer updates on every grant.
REQ-029 Macro undefined: fixed CPU priority per REQ-015; no pointer register exists.

Structure
REQ-030 DATA_WIDTH and FUNCT3_SB/SH/SW/LB/LH/LW/LBU/LHU come from the shared defines package; a pending-read enum (NONE, CPU_RD, DMA_RD) is added there.
REQ-031 One sub-module, dmem_lane_align: combinational store byte-enable/replication and load extraction/extension.

Verification
REQ-032 CPU SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> cpu_rvalid_o next cycle, cpu_rdata_o=0xDEADBEEF, one stall cycle.
REQ-033 CPU SB 0x80 to addr 0x203 on word 0xAAAAAAAA -> mem_we_o=1000; LB 0x203 returns 0xFFFFFF80, LBU returns 0x00000080.
REQ-034 CPU and DMA request same cycle, fixed priority -> CPU granted, cpu_stall_o=0, DMA granted next cycle; DMA starves while CPU holds req.
REQ-035 DMEM_ARB_RR_EN, both requesting continuously for 4 cycles -> grants alternate CPU, DMA, CPU, DMA.
REQ-036 CPU LW addr 0x102 -> cpu_misalign_o=1 one cycle, mem_en_o=0, no cpu_rvalid_o.
REQ-037 Reset asserted the cycle after a DMA read grant -> dma_rvalid_o stays 0, all outputs 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared defines for the data-memory arbiter: data width, RISC-V load/store
// funct3 encodings and the pending-read tracker states.
package dmem_arbiter_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        CPU_RD = 2'd1,
        DMA_RD = 2'd2
    } pend_rd_e;

endpackage

// File: rtl/dmem_arbiter_lane_align.sv
// dmem_lane_align: combinational store lane steering (byte enables, data
// replication, misalignment) and load byte/halfword extraction with extension.
module dmem_lane_align
    import dmem_arbiter_pkg::*;
(
    input  logic [2:0]            acc_funct3,
    input  logic [1:0]            acc_offset,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [3:0]            st_be,
    output logic [DATA_WIDTH-1:0] st_lane_data,
    output logic                  misaligned,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_offset,
    input  logic [DATA_WIDTH-1:0] ld_word,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [DATA_WIDTH-1:0] ld_shifted;

    always_comb begin
        st_be        = 4'b1111;
        st_lane_data = st_data;
        misaligned   = 1'b0;
        case (acc_funct3)
            3'b000, 3'b100: begin
                st_be        = 4'b0001 << acc_offset;
                st_lane_data = {4{st_data[7:0]}};
            end
            3'b001, 3'b101: begin
                st_be        = 4'b0011 << {acc_offset[1], 1'b0};
                st_lane_data = {2{st_data[15:0]}};
                misaligned   = acc_offset[0];
            end
            default: begin
                misaligned = (acc_offset != 2'b00);
            end
        endcase
    end

    // Bring the addressed byte/halfword down to bit 0 before extending.
    assign ld_shifted = ld_word >> {ld_offset, 3'b000};

    always_comb begin
        ld_data = ld_word;
        case (ld_funct3)
            FUNCT3_LB:  ld_data = {{(DATA_WIDTH-8){ld_shifted[7]}}, ld_shifted[7:0]};
            FUNCT3_LH:  ld_data = {{(DATA_WIDTH-16){ld_shifted[15]}}, ld_shifted[15:0]};
            FUNCT3_LBU: ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_shifted[7:0]};
            FUNCT3_LHU: ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_shifted[15:0]};
            default:    ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a DMA loader port.
// Define DMEM_ARB_RR_EN for round-robin on ties; default is fixed CPU priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [2:0]            cpu_funct3_i,
    input  logic [DATA_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_stall_o,
    output logic                  cpu_misalign_o,
    output logic                  cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    input  logic                  dma_req_i,
    input  logic                  dma_we_i,
    input  logic [3:0]            dma_be_i,
    input  logic [DATA_WIDTH-1:0] dma_addr_i,
    input  logic [DATA_WIDTH-1:0] dma_wdata_i,
    output logic                  dma_gnt_o,
    output logic                  dma_rvalid_o,
    output logic [DATA_WIDTH-1:0] dma_rdata_o,
    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);

    pend_rd_e              state_q, state_d;
    logic [2:0]            ld_funct3_q;
    logic [1:0]            ld_offset_q;
    logic                  cpu_wins;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_lane_data;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] ld_data;

    dmem_lane_align u_lane_align (
        .acc_funct3   (cpu_funct3_i),
        .acc_offset   (cpu_addr_i[1:0]),
        .st_data      (cpu_wdata_i),
        .st_be        (st_be),
        .st_lane_data (st_lane_data),
        .misaligned   (misaligned),
        .ld_funct3    (ld_funct3_q),
        .ld_offset    (ld_offset_q),
        .ld_word      (mem_rdata_i),
        .ld_data      (ld_data)
    );

`ifdef DMEM_ARB_RR_EN
    logic cpu_last_q;

    // Remembers which port the most recent grant went to; misaligned CPU grants count.
    always_ff @(posedge clk) begin
        if (rst)            cpu_last_q <= 1'b0;
        else if (cpu_gnt_o) cpu_last_q <= 1'b1;
        else if (dma_gnt_o) cpu_last_q <= 1'b0;
    end

    assign cpu_wins = ~dma_req_i | ~cpu_last_q;
`else
    assign cpu_wins = 1'b1;
`endif

    assign cpu_gnt_o      = ~rst & cpu_req_i & cpu_wins;
    assign dma_gnt_o      = ~rst & dma_req_i & ~cpu_gnt_o;
    assign cpu_misalign_o = cpu_gnt_o & misaligned;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        state_d     = NONE;
        if (cpu_gnt_o && !misaligned) begin
            mem_en_o    = 1'b1;
            mem_we_o    = cpu_we_i ? st_be : 4'b0000;
            mem_addr_o  = cpu_addr_i & WORD_MASK;
            mem_wdata_o = st_lane_data;
            if (!cpu_we_i) state_d = CPU_RD;
        end else if (dma_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = dma_we_i ? dma_be_i : 4'b0000;
            mem_addr_o  = dma_addr_i & WORD_MASK;
            mem_wdata_o = dma_wdata_i;
            if (!dma_we_i) state_d = DMA_RD;
        end
    end

    // Load width/offset must survive until the data comes back next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= NONE;
            ld_funct3_q <= 3'b000;
            ld_offset_q <= 2'b00;
        end else begin
            state_q <= state_d;
            if (state_d == CPU_RD) begin
                ld_funct3_q <= cpu_funct3_i;
                ld_offset_q <= cpu_addr_i[1:0];
            end
        end
    end

    assign cpu_rvalid_o = ~rst & (state_q == CPU_RD);
    assign dma_rvalid_o = ~rst & (state_q == DMA_RD);
    assign cpu_rdata_o  = cpu_rvalid_o ? ld_data : '0;
    assign dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : '0;

    // A CPU load is pending from its grant cycle until its data returns.
    assign cpu_stall_o = ~rst & ((cpu_req_i & ~cpu_gnt_o)
                               | (state_d == CPU_RD)
                               | ((state_q == CPU_RD) & ~cpu_rvalid_o));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a synchronous-read memory model.
// Expectations for tie cycles depend on DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cpu_req_i, cpu_we_i;
    logic [2:0]            cpu_funct3_i;
    logic [DATA_WIDTH-1:0] cpu_addr_i, cpu_wdata_i;
    logic                  cpu_gnt_o, cpu_stall_o, cpu_misalign_o, cpu_rvalid_o;
    logic [DATA_WIDTH-1:0] cpu_rdata_o;
    logic                  dma_req_i, dma_we_i;
    logic [3:0]            dma_be_i;
    logic [DATA_WIDTH-1:0] dma_addr_i, dma_wdata_i;
    logic                  dma_gnt_o, dma_rvalid_o;
    logic [DATA_WIDTH-1:0] dma_rdata_o;
    logic                  mem_en_o;
    logic [3:0]            mem_we_o;
    logic [DATA_WIDTH-1:0] mem_addr_o, mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i = '0;

    logic [31:0] mem [0:1023];
    int          errors = 0;
    int          checks = 0;
    logic        exp_cpu;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_funct3_i(cpu_funct3_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_gnt_o(cpu_gnt_o), .cpu_stall_o(cpu_stall_o), .cpu_misalign_o(cpu_misalign_o),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_be_i(dma_be_i),
        .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i),
        .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Synchronous-read, byte-writable memory behind the arbiter.
    always @(posedge clk) begin
        if (mem_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) mem[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            if (mem_we_o == 4'b0000) mem_rdata_i <= mem[mem_addr_o[11:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_acc(input logic req, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req_i = req; cpu_we_i = we; cpu_funct3_i = f3;
        cpu_addr_i = addr; cpu_wdata_i = wdata;
    endtask

    task automatic dma_acc(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        dma_req_i = req; dma_we_i = we; dma_be_i = be;
        dma_addr_i = addr; dma_wdata_i = wdata;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Reset with both ports requesting: everything quiet.
        rst = 1'b1;
        cpu_acc(1, 1, FUNCT3_SW, 32'h100, 32'h1);
        dma_acc(1, 0, 4'h0, 32'h200, 32'h0);
        #1;
        check("rst_cpu_gnt", cpu_gnt_o, 0);
        check("rst_dma_gnt", dma_gnt_o, 0);
        check("rst_stall", cpu_stall_o, 0);
        check("rst_misalign", cpu_misalign_o, 0);
        check("rst_mem_en", mem_en_o, 0);
        check("rst_mem_we", mem_we_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_wdata", mem_wdata_o, 0);
        check("rst_cpu_rvalid", cpu_rvalid_o, 0);
        check("rst_dma_rvalid", dma_rvalid_o, 0);
        check("rst_cpu_rdata", cpu_rdata_o, 0);
        check("rst_dma_rdata", dma_rdata_o, 0);
        tick(); tick();
        rst = 1'b0;

        // SW then LW at 0x100.
        cpu_acc(1, 1, FUNCT3_SW, 32'h100, 32'hDEADBEEF);
        dma_acc(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check("sw_gnt", cpu_gnt_o, 1);
        check("sw_stall", cpu_stall_o, 0);
        check("sw_mem_en", mem_en_o, 1);
        check("sw_mem_we", mem_we_o, 4'hF);
        check("sw_mem_addr", mem_addr_o, 32'h100);
        check("sw_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        tick();
        cpu_acc(1, 0, FUNCT3_LW, 32'h100, 32'h0);
        #1;
        check("lw_gnt", cpu_gnt_o, 1);
        check("lw_stall_grant", cpu_stall_o, 1);
        check("lw_mem_we", mem_we_o, 0);
        check("lw_mem_en", mem_en_o, 1);
        tick();
        cpu_acc(0, 0, FUNCT3_LW, 32'h0, 32'h0);
        #1;
        check("lw_rvalid", cpu_rvalid_o, 1);
        check("lw_rdata", cpu_rdata_o, 32'hDEADBEEF);
        check("lw_stall_ret", cpu_stall_o, 0);
        tick();
        #1;
        check("lw_rvalid_once", cpu_rvalid_o, 0);

        // DMA word write; low address bits ignored.
        dma_acc(1, 1, 4'hF, 32'h201, 32'hAAAAAAAA);
        #1;
        check("dmaw_gnt", dma_gnt_o, 1);
        check("dmaw_mem_we", mem_we_o, 4'hF);
        check("dmaw_mem_addr", mem_addr_o, 32'h200);
        check("dmaw_mem_wdata", mem_wdata_o, 32'hAAAAAAAA);
        tick();

        // Both requesting for 4 cycles after a DMA grant.
        for (int i = 0; i < 4; i++) begin
            cpu_acc(1, 1, FUNCT3_SW, 32'h300, 32'h11111111);
            dma_acc(1, 1, 4'hF, 32'h304, 32'h22222222);
            #1;
`ifdef DMEM_ARB_RR_EN
            exp_cpu = (i % 2 == 0);
`else
            exp_cpu = 1'b1;
`endif
            check($sformatf("tie%0d_cpu_gnt", i), cpu_gnt_o, exp_cpu);
            check($sformatf("tie%0d_dma_gnt", i), dma_gnt_o, !exp_cpu);
            check($sformatf("tie%0d_stall", i), cpu_stall_o, !exp_cpu);
            tick();
        end
        cpu_acc(0, 0, FUNCT3_SW, 32'h0, 32'h0);
        #1;
        check("dma_after_cpu_gnt", dma_gnt_o, 1);
        check("dma_after_cpu_addr", mem_addr_o, 32'h304);
        tick();
        dma_acc(0, 0, 4'h0, 32'h0, 32'h0);

        // SB 0x80 into byte 3 of 0xAAAAAAAA, then byte/halfword loads back-to-back.
        cpu_acc(1, 1, FUNCT3_SB, 32'h203, 32'h12345680);
        #1;
        check("sb_mem_we", mem_we_o, 4'b1000);
        check("sb_mem_wdata", mem_wdata_o, 32'h80808080);
        check("sb_mem_addr", mem_addr_o, 32'h200);
        tick();
        cpu_acc(1, 0, FUNCT3_LB, 32'h203, 32'h0);
        #1;
        check("lb_stall", cpu_stall_o, 1);
        tick();
        cpu_acc(1, 0, FUNCT3_LBU, 32'h203, 32'h0);
        #1;
        check("lb_rvalid", cpu_rvalid_o, 1);
        check("lb_rdata", cpu_rdata_o, 32'hFFFFFF80);
        check("lbu_gnt", cpu_gnt_o, 1);
        check("lbu_stall", cpu_stall_o, 1);
        tick();
        cpu_acc(1, 0, FUNCT3_LH, 32'h202, 32'h0);
        #1;
        check("lbu_rdata", cpu_rdata_o, 32'h00000080);
        tick();
        cpu_acc(1, 1, FUNCT3_SH, 32'h202, 32'h00001234);
        #1;
        check("lh_rdata", cpu_rdata_o, 32'hFFFF80AA);
        check("sh_mem_we", mem_we_o, 4'b1100);
        check("sh_mem_wdata", mem_wdata_o, 32'h12341234);
        check("sh_stall", cpu_stall_o, 0);
        tick();
        cpu_acc(1, 0, FUNCT3_LHU, 32'h202, 32'h0);
        #1;
        check("sh_no_rvalid", cpu_rvalid_o, 0);
        tick();
        cpu_acc(0, 0, FUNCT3_LW, 32'h0, 32'h0);
        #1;
        check("lhu_rdata", cpu_rdata_o, 32'h00001234);
        tick();

        // Misaligned LW and SH.
        cpu_acc(1, 0, FUNCT3_LW, 32'h102, 32'h0);
        #1;
        check("mis_lw_gnt", cpu_gnt_o, 1);
        check("mis_lw_flag", cpu_misalign_o, 1);
        check("mis_lw_mem_en", mem_en_o, 0);
        check("mis_lw_stall", cpu_stall_o, 0);
        tick();
        cpu_acc(1, 1, FUNCT3_SH, 32'h201, 32'h5555);
        #1;
        check("mis_lw_no_rvalid", cpu_rvalid_o, 0);
        check("mis_sh_flag", cpu_misalign_o, 1);
        check("mis_sh_mem_we", mem_we_o, 0);
        tick();
        cpu_acc(0, 0, FUNCT3_LW, 32'h0, 32'h0);
        #1;
        check("mis_flag_clear", cpu_misalign_o, 0);

        // DMA read return overlaps a new CPU grant.
        dma_acc(1, 0, 4'h0, 32'h300, 32'h0);
        #1;
        check("dmar_gnt", dma_gnt_o, 1);
        check("dmar_mem_we", mem_we_o, 0);
        tick();
        cpu_acc(1, 0, FUNCT3_LW, 32'h304, 32'h0);
        #1;
        check("ovl_dma_rvalid", dma_rvalid_o, 1);
        check("ovl_dma_rdata", dma_rdata_o, 32'h11111111);
        check("ovl_cpu_gnt", cpu_gnt_o, 1);
        check("ovl_dma_gnt", dma_gnt_o, 0);
        check("ovl_mem_addr", mem_addr_o, 32'h304);
        tick();
        cpu_acc(0, 0, FUNCT3_LW, 32'h0, 32'h0);
        #1;
        check("ovl_cpu_rdata", cpu_rdata_o, 32'h22222222);
        check("ovl_dma_gnt2", dma_gnt_o, 1);
        tick();

        // Reset the cycle after a DMA read grant drops the response.
        rst = 1'b1;
        dma_acc(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check("rstrd_dma_rvalid", dma_rvalid_o, 0);
        check("rstrd_dma_rdata", dma_rdata_o, 0);
        check("rstrd_mem_en", mem_en_o, 0);
        check("rstrd_stall", cpu_stall_o, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rstrd_after1", dma_rvalid_o, 0);
        tick();
        check("rstrd_after2", dma_rvalid_o, 0);
        check("rstrd_cpu_rvalid", cpu_rvalid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
